circuito_exp5_jogo: RTL and testbench
=====================================

# circuito_exp5_jogo

Sequence-memory game controller (Genius-style): a fixed 16-play sequence stored in on-chip ROM must be reproduced on four one-hot keys, round by round. Round r requires plays 0..r-1. A wrong key or a missed deadline ends the game. Top-level block of experiment 5; drives the board LEDs and six active-low 7-segment debug displays.

## Interface
- TIMEOUT_CYCLES, 3000: clock cycles allowed per play (3 s at 1 kHz).
- N_JOGADAS, 16: sequence length and ROM depth.
- clock  in  1  system clock, 1 kHz nominal.
- reset  in  1  asynchronous, active-low.
- iniciar  in  1  start/restart request, sampled synchronously.
- chaves  in  4  one-hot play keys (0000 = idle).
- pronto  out  1  game over (win, error or timeout).
- acertou  out  1  full sequence completed.
- errou  out  1  wrong play or timeout.
- leds  out  4  echo of chaves.
- db_igual  out  1  registered play equals ROM data.
- db_tem_jogada  out  1  |chaves.
- db_endmenorquelimite  out  1  address < limit.
- db_clock  out  1  clock passthrough.
- db_timeout, db_contagem, db_memoria, db_estado, db_jogadafeita, db_limite  out  7 each  active-low 7-seg (gfedcba) of: timeout flag, address, ROM data, state code, registered play, limit.

## Operation
- ROM, addresses 0..15: 1,2,4,8,4,2,1,1,2,2,4,4,8,8,1,4 (hex, 4-bit).
- Play detection: register |chaves; one-cycle jogada pulse on 0→nonzero transition. Holding keys produces no further pulses.
- States and 4-bit codes: inicial 0, preparacao 1, espera 2, registra 3, comparacao 4, proximo 5, proxima_rodada 6, fim_acertou A, fim_errou E, fim_timeout C.
- inicial → preparacao on iniciar. preparacao: address=0, limit=0, registered play=0 → espera.
- espera: timeout counter runs; jogada → registra (latch chaves into play register) → comparacao.
- comparacao: mismatch → fim_errou; match and address<limit → proximo (address+1) → espera; match, address==limit, limit<15 → proxima_rodada (limit+1, address=0) → espera; match at limit 15 → fim_acertou.
- Timeout counter clears on entering espera; reaching TIMEOUT_CYCLES in espera → fim_timeout.
- End states hold; iniciar from any end state → preparacao. iniciar ignored elsewhere.
- Outputs: pronto=1 in all end states; acertou=1 only in fim_acertou; errou=1 in fim_errou and fim_timeout; timeout flag=1 only in fim_timeout.

## Timing
- reset low: state inicial, address 0, limit 0, play register 0, timeout counter 0, edge register 0; pronto/acertou/errou 0; 7-seg outputs show 0 (7'b1000000), db_estado shows 0.
- Key press to comparacao decision: 3 cycles (detect, registra, comparacao).
- Counters and play register update on rising clock edge; all flags are Moore outputs from current state.
- Timeout asserts exactly TIMEOUT_CYCLES cycles after entering espera, unless a jogada pulse arrives first; a pulse in the same cycle as expiry wins (play taken).
- reset mid-game returns to inicial immediately, regardless of state.

## Configuration
- TIMEOUT_EN defined: timeout counter and fim_timeout present as above.
- Undefined: no counter, espera waits indefinitely, db_timeout permanently shows 0, fim_timeout unreachable.

## Structure
- Package circuito_exp5_pkg: state enum and codes, ROM contents constant, TIMEOUT_CYCLES and N_JOGADAS defaults.
- Sub-module hexa7seg (4-bit value → active-low 7 segments), instantiated six times.
- Datapath (counters, ROM, play register, comparator) and FSM in the top.

## Test plan
- Reset low 10 cycles, release, pulse iniciar: state passes 1→2, db_contagem and db_limite show 0, pronto=0.
- Round 1 key 0001, round 2 keys 0001,0010 (5 cycles pressed, 5 released each): db_limite reaches 2, state 2, errou=0.
- Round 3: 0001, 0010, then 3100 idle cycles: fim_timeout, pronto=1, errou=1, db_timeout shows 1; a later key 0010 is ignored.
- Restart with iniciar from fim_timeout: state 1 then 2, address=0, limit=0, flags cleared.
- Round 1 with key 0010: fim_errou, errou=1, db_igual=0, db_estado shows E.
- Full 16-round correct sequence (timeout disabled or fast plays): fim_acertou, acertou=1, pronto=1, db_limite shows F.

Source files
------------

// File: rtl/circuito_exp5_pkg.sv
// Shared types and constants for the sequence-memory game: state codes,
// the fixed 16-play sequence and default timing parameters.
package circuito_exp5_pkg;

   localparam int TIMEOUT_CYCLES_DEF = 3000;
   localparam int N_JOGADAS_DEF      = 16;

   typedef enum logic [3:0] {
      INICIAL        = 4'h0,
      PREPARACAO     = 4'h1,
      ESPERA         = 4'h2,
      REGISTRA       = 4'h3,
      COMPARACAO     = 4'h4,
      PROXIMO        = 4'h5,
      PROXIMA_RODADA = 4'h6,
      FIM_ACERTOU    = 4'hA,
      FIM_TIMEOUT    = 4'hC,
      FIM_ERROU      = 4'hE
   } estado_t;

   function automatic logic [3:0] rom_jogada(input logic [3:0] addr);
      logic [3:0] dado;
      case (addr)
         4'h0: dado = 4'h1;
         4'h1: dado = 4'h2;
         4'h2: dado = 4'h4;
         4'h3: dado = 4'h8;
         4'h4: dado = 4'h4;
         4'h5: dado = 4'h2;
         4'h6: dado = 4'h1;
         4'h7: dado = 4'h1;
         4'h8: dado = 4'h2;
         4'h9: dado = 4'h2;
         4'hA: dado = 4'h4;
         4'hB: dado = 4'h4;
         4'hC: dado = 4'h8;
         4'hD: dado = 4'h8;
         4'hE: dado = 4'h1;
         default: dado = 4'h4;
      endcase
      return dado;
   endfunction

endpackage

// File: rtl/circuito_exp5_jogo_hexa7seg.sv
// 4-bit value to active-low 7-segment pattern, bit order gfedcba.
module hexa7seg (
   input  logic [3:0] valor_i,
   output logic [6:0] seg_o
);

   always_comb begin
      seg_o = 7'b1111111;
      case (valor_i)
         4'h0: seg_o = 7'b1000000;
         4'h1: seg_o = 7'b1111001;
         4'h2: seg_o = 7'b0100100;
         4'h3: seg_o = 7'b0110000;
         4'h4: seg_o = 7'b0011001;
         4'h5: seg_o = 7'b0010010;
         4'h6: seg_o = 7'b0000010;
         4'h7: seg_o = 7'b1111000;
         4'h8: seg_o = 7'b0000000;
         4'h9: seg_o = 7'b0010000;
         4'hA: seg_o = 7'b0001000;
         4'hB: seg_o = 7'b0000011;
         4'hC: seg_o = 7'b1000110;
         4'hD: seg_o = 7'b0100001;
         4'hE: seg_o = 7'b0000110;
         default: seg_o = 7'b0001110;
      endcase
   end

endmodule

// File: rtl/circuito_exp5_jogo.sv
// Genius-style sequence-memory game: FSM, datapath and debug displays.
// Define TIMEOUT_EN to enable the per-play deadline and the fim_timeout state.
module circuito_exp5_jogo
   import circuito_exp5_pkg::*;
#(
`ifdef TIMEOUT_EN
   parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
`endif
   parameter int N_JOGADAS = N_JOGADAS_DEF
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       iniciar,
   input  logic [3:0] chaves,
   output logic       pronto,
   output logic       acertou,
   output logic       errou,
   output logic [3:0] leds,
   output logic       db_igual,
   output logic       db_tem_jogada,
   output logic       db_endmenorquelimite,
   output logic       db_clock,
   output logic [6:0] db_timeout,
   output logic [6:0] db_contagem,
   output logic [6:0] db_memoria,
   output logic [6:0] db_estado,
   output logic [6:0] db_jogadafeita,
   output logic [6:0] db_limite
);

   localparam logic [3:0] ULTIMA = 4'(N_JOGADAS - 1);

   estado_t    state_q, state_d;
   logic [3:0] addr_q, addr_d;
   logic [3:0] lim_q, lim_d;
   logic [3:0] play_q, play_d;
   logic       tem_q;
   logic       pronto_q, acertou_q, errou_q, tmo_flag_q;

   logic       tem_jogada, jogada, igual, end_menor, expirou;
   logic [3:0] rom_dado;

   assign tem_jogada = |chaves;
   assign jogada     = tem_jogada & ~tem_q;
   assign rom_dado   = rom_jogada(addr_q);
   assign igual      = (play_q == rom_dado);
   assign end_menor  = (addr_q < lim_q);

`ifdef TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [TMO_W-1:0] tmo_q;

   // Held at zero outside espera, so it restarts on every entry.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) tmo_q <= '0;
      else if (state_q != ESPERA) tmo_q <= '0;
      else tmo_q <= tmo_q + 1'b1;
   end
   assign expirou = (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));
`else
   assign expirou = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      lim_d   = lim_q;
      play_d  = play_q;
      case (state_q)
         INICIAL: if (iniciar) state_d = PREPARACAO;
         PREPARACAO: begin
            addr_d  = '0;
            lim_d   = '0;
            play_d  = '0;
            state_d = ESPERA;
         end
         // A play arriving in the expiry cycle takes priority.
         ESPERA: begin
            if (jogada) state_d = REGISTRA;
            else if (expirou) state_d = FIM_TIMEOUT;
         end
         REGISTRA: begin
            play_d  = chaves;
            state_d = COMPARACAO;
         end
         COMPARACAO: begin
            if (!igual) state_d = FIM_ERROU;
            else if (end_menor) state_d = PROXIMO;
            else if (lim_q != ULTIMA) state_d = PROXIMA_RODADA;
            else state_d = FIM_ACERTOU;
         end
         PROXIMO: begin
            addr_d  = addr_q + 4'd1;
            state_d = ESPERA;
         end
         PROXIMA_RODADA: begin
            lim_d   = lim_q + 4'd1;
            addr_d  = '0;
            state_d = ESPERA;
         end
         FIM_ACERTOU, FIM_ERROU, FIM_TIMEOUT: if (iniciar) state_d = PREPARACAO;
         default: state_d = INICIAL;
      endcase
   end

   // Flags are decoded from the next state so they line up with state_q.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q    <= INICIAL;
         addr_q     <= '0;
         lim_q      <= '0;
         play_q     <= '0;
         tem_q      <= 1'b0;
         pronto_q   <= 1'b0;
         acertou_q  <= 1'b0;
         errou_q    <= 1'b0;
         tmo_flag_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         lim_q      <= lim_d;
         play_q     <= play_d;
         tem_q      <= tem_jogada;
         pronto_q   <= (state_d == FIM_ACERTOU) || (state_d == FIM_ERROU) ||
                       (state_d == FIM_TIMEOUT);
         acertou_q  <= (state_d == FIM_ACERTOU);
         errou_q    <= (state_d == FIM_ERROU) || (state_d == FIM_TIMEOUT);
         tmo_flag_q <= (state_d == FIM_TIMEOUT);
      end
   end

   assign pronto               = pronto_q;
   assign acertou              = acertou_q;
   assign errou                = errou_q;
   assign leds                 = chaves;
   assign db_igual             = igual;
   assign db_tem_jogada        = tem_jogada;
   assign db_endmenorquelimite = end_menor;
   assign db_clock             = clock;

   hexa7seg u_hex_timeout (.valor_i({3'b000, tmo_flag_q}), .seg_o(db_timeout));
   hexa7seg u_hex_contagem (.valor_i(addr_q), .seg_o(db_contagem));
   hexa7seg u_hex_memoria (.valor_i(rom_dado), .seg_o(db_memoria));
   hexa7seg u_hex_estado (.valor_i(state_q), .seg_o(db_estado));
   hexa7seg u_hex_jogada (.valor_i(play_q), .seg_o(db_jogadafeita));
   hexa7seg u_hex_limite (.valor_i(lim_q), .seg_o(db_limite));

endmodule

// File: tb/tb_circuito_exp5_jogo.sv
// Directed bench for circuito_exp5_jogo; timeout scenario follows TIMEOUT_EN.
module tb_circuito_exp5_jogo;

   logic       clock = 1'b0;
   logic       reset;
   logic       iniciar;
   logic [3:0] chaves;
   logic       pronto, acertou, errou;
   logic [3:0] leds;
   logic       db_igual, db_tem_jogada, db_endmenorquelimite, db_clock;
   logic [6:0] db_timeout, db_contagem, db_memoria, db_estado, db_jogadafeita, db_limite;

   int n_vec = 0;
   int n_err = 0;

   logic [3:0] seq [16] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h4, 4'h2, 4'h1, 4'h1,
                            4'h2, 4'h2, 4'h4, 4'h4, 4'h8, 4'h8, 4'h1, 4'h4};

   always #5 clock = ~clock;

   circuito_exp5_jogo dut (
      .clock(clock), .reset(reset), .iniciar(iniciar), .chaves(chaves),
      .pronto(pronto), .acertou(acertou), .errou(errou), .leds(leds),
      .db_igual(db_igual), .db_tem_jogada(db_tem_jogada),
      .db_endmenorquelimite(db_endmenorquelimite), .db_clock(db_clock),
      .db_timeout(db_timeout), .db_contagem(db_contagem), .db_memoria(db_memoria),
      .db_estado(db_estado), .db_jogadafeita(db_jogadafeita), .db_limite(db_limite)
   );

   function automatic logic [6:0] seg(input logic [3:0] v);
      logic [6:0] s;
      case (v)
         4'h0: s = 7'b1000000;  4'h1: s = 7'b1111001;
         4'h2: s = 7'b0100100;  4'h3: s = 7'b0110000;
         4'h4: s = 7'b0011001;  4'h5: s = 7'b0010010;
         4'h6: s = 7'b0000010;  4'h7: s = 7'b1111000;
         4'h8: s = 7'b0000000;  4'h9: s = 7'b0010000;
         4'hA: s = 7'b0001000;  4'hB: s = 7'b0000011;
         4'hC: s = 7'b1000110;  4'hD: s = 7'b0100001;
         4'hE: s = 7'b0000110;  default: s = 7'b0001110;
      endcase
      return s;
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic press(input logic [3:0] k);
      chaves = k;
      tick(5);
      chaves = 4'b0000;
      tick(5);
   endtask

   task automatic start_game();
      iniciar = 1'b1;
      tick(1);
      iniciar = 1'b0;
      check_eq("start_prep_state", 32'(db_estado), 32'(seg(4'h1)));
      tick(1);
      check_eq("start_wait_state", 32'(db_estado), 32'(seg(4'h2)));
      check_eq("start_addr", 32'(db_contagem), 32'(seg(4'h0)));
      check_eq("start_limit", 32'(db_limite), 32'(seg(4'h0)));
      check_eq("start_pronto", 32'(pronto), 32'd0);
      check_eq("start_errou", 32'(errou), 32'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no finish, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b0; iniciar = 1'b0; chaves = 4'b0000;
      tick(10);
      check_eq("rst_state", 32'(db_estado), 32'(seg(4'h0)));
      check_eq("rst_addr", 32'(db_contagem), 32'(seg(4'h0)));
      check_eq("rst_limit", 32'(db_limite), 32'(seg(4'h0)));
      check_eq("rst_play", 32'(db_jogadafeita), 32'(seg(4'h0)));
      check_eq("rst_timeout", 32'(db_timeout), 32'(seg(4'h0)));
      check_eq("rst_flags", 32'({pronto, acertou, errou}), 32'd0);
      reset = 1'b1;
      tick(1);
      check_eq("idle_state", 32'(db_estado), 32'(seg(4'h0)));
      start_game();

      press(4'h1);
      check_eq("r1_limit", 32'(db_limite), 32'(seg(4'h1)));
      press(4'h1);
      press(4'h2);
      check_eq("r2_limit", 32'(db_limite), 32'(seg(4'h2)));
      check_eq("r2_state", 32'(db_estado), 32'(seg(4'h2)));
      check_eq("r2_errou", 32'(errou), 32'd0);

      // Round 3, first key traced through detect, registra, comparacao.
      chaves = 4'h1;
      #1;
      check_eq("leds_echo", 32'(leds), 32'h1);
      check_eq("tem_jogada", 32'(db_tem_jogada), 32'd1);
      tick(1);
      check_eq("lat_registra", 32'(db_estado), 32'(seg(4'h3)));
      tick(1);
      check_eq("lat_comparacao", 32'(db_estado), 32'(seg(4'h4)));
      check_eq("lat_play", 32'(db_jogadafeita), 32'(seg(4'h1)));
      check_eq("lat_igual", 32'(db_igual), 32'd1);
      check_eq("lat_addr_lt_lim", 32'(db_endmenorquelimite), 32'd1);
      tick(1);
      check_eq("lat_proximo", 32'(db_estado), 32'(seg(4'h5)));
      tick(2);
      check_eq("held_key_no_pulse", 32'(db_estado), 32'(seg(4'h2)));
      chaves = 4'h0;
      tick(5);
      press(4'h2);
      check_eq("r3_addr", 32'(db_contagem), 32'(seg(4'h2)));

`ifdef TIMEOUT_EN
      tick(2990);
      check_eq("tmo_not_yet", 32'(db_estado), 32'(seg(4'h2)));
      tick(110);
      check_eq("tmo_state", 32'(db_estado), 32'(seg(4'hC)));
      check_eq("tmo_flags", 32'({pronto, acertou, errou}), 32'b101);
      check_eq("tmo_display", 32'(db_timeout), 32'(seg(4'h1)));
      press(4'h2);
      check_eq("tmo_key_ignored", 32'(db_estado), 32'(seg(4'hC)));
`else
      tick(3100);
      check_eq("no_tmo_state", 32'(db_estado), 32'(seg(4'h2)));
      check_eq("no_tmo_display", 32'(db_timeout), 32'(seg(4'h0)));
      check_eq("no_tmo_pronto", 32'(pronto), 32'd0);
      iniciar = 1'b1;
      tick(1);
      iniciar = 1'b0;
      tick(1);
      check_eq("iniciar_ignored", 32'(db_estado), 32'(seg(4'h2)));
      check_eq("iniciar_ign_lim", 32'(db_limite), 32'(seg(4'h2)));
      press(4'h1);
      check_eq("r3_wrong_state", 32'(db_estado), 32'(seg(4'hE)));
`endif

      start_game();
      press(4'h2);
      check_eq("err_state", 32'(db_estado), 32'(seg(4'hE)));
      check_eq("err_flags", 32'({pronto, acertou, errou}), 32'b101);
      check_eq("err_igual", 32'(db_igual), 32'd0);
      check_eq("err_timeout_disp", 32'(db_timeout), 32'(seg(4'h0)));

      start_game();
      for (int r = 1; r <= 16; r++) begin
         for (int i = 0; i < r; i++) press(seq[i]);
         if (r < 16) begin
            check_eq($sformatf("round%0d_limit", r), 32'(db_limite), 32'(seg(4'(r))));
            check_eq($sformatf("round%0d_state", r), 32'(db_estado), 32'(seg(4'h2)));
         end
      end
      check_eq("win_state", 32'(db_estado), 32'(seg(4'hA)));
      check_eq("win_flags", 32'({pronto, acertou, errou}), 32'b110);
      check_eq("win_limit", 32'(db_limite), 32'(seg(4'hF)));
      tick(20);
      check_eq("win_holds", 32'(db_estado), 32'(seg(4'hA)));

      reset = 1'b0;
      #1;
      check_eq("async_rst_state", 32'(db_estado), 32'(seg(4'h0)));
      check_eq("async_rst_flags", 32'({pronto, acertou, errou}), 32'd0);
      check_eq("async_rst_limit", 32'(db_limite), 32'(seg(4'h0)));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
